instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning program-counter and instruction-address width.
REQ-002 SHALL have parameter START_ADDR, default 0, meaning the first instruction address after start.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high, sampled on clk rising edge.
REQ-005 SHALL have port start  input  1  begin execution at START_ADDR (level, sampled each cycle).
REQ-006 SHALL have port done_i  input  1  halt request from the instruction decoder for the current instruction.
REQ-007 SHALL have port stall  input  1  hold the current instruction and PC (multi-cycle op in progress).
REQ-008 SHALL have port jmp_en  input  1  absolute redirect request for the current instruction.
REQ-009 SHALL have port jmp_addr  input  PC_W  absolute redirect target.
REQ-010 SHALL have port br_en  input  1  PC-relative redirect request for the current instruction.
REQ-011 SHALL have port br_off  input  8  signed two's-complement branch offset.
REQ-012 SHALL have port imem_addr  output  PC_W  instruction memory address (combinational from state/inputs).
REQ-013 SHALL have port imem_rdata  input  9  synchronous instruction memory data, valid one cycle after imem_addr.
REQ-014 SHALL have port instr  output  9  instruction to the decoder; equals imem_rdata when instr_valid=1, else 9'h000.
REQ-015 SHALL have port instr_valid  output  1  instr is a live instruction at address pc.
REQ-016 SHALL have port pc  output  PC_W  address of the instruction on instr.
REQ-017 SHALL have port halted  output  1  high while in HALT.
REQ-018 SHALL have port retired  output  16  count of retired instructions, saturating.

Function
REQ-019 SHALL implement states IDLE, RUN, HALT; instr_valid=1 only in RUN.
REQ-020 In IDLE and HALT SHALL drive imem_addr=START_ADDR so the first instruction is ready on RUN entry.
REQ-021 IDLE -> RUN when start=1; pc<=START_ADDR, retired<=0; first RUN cycle presents instr at START_ADDR with zero bubble.
REQ-022 HALT -> RUN when start=1 with the same actions as REQ-021; otherwise HALT holds pc and retired.
REQ-023 In RUN, SHALL apply per-cycle priority: done_i > stall > jmp_en > br_en > sequential.
REQ-024 done_i=1 in RUN: next state HALT, pc holds, instruction counts as retired, imem_addr=START_ADDR.
REQ-025 stall=1 (done_i=0): imem_addr=pc, pc holds, instr stays identical next cycle, no retire.
REQ-026 jmp_en=1: imem_addr=jmp_addr, pc<=jmp_addr; target instruction valid next cycle, no bubble.
REQ-027 br_en=1 (jmp_en=0): target = pc + sign-extended br_off, modulo 2^PC_W; imem_addr=target, pc<=target.
REQ-028 Sequential: imem_addr=pc+1 modulo 2^PC_W, pc<=imem_addr; pc=2^PC_W-1 wraps to 0.
REQ-029 retired SHALL increment by 1 in each RUN cycle with stall=0 or done_i=1, saturating at 16'hFFFF.
REQ-030 start=1 while in RUN SHALL be ignored.
REQ-031 jmp_en, br_en, stall, done_i SHALL be ignored outside RUN.
REQ-032 halted SHALL be registered state decode, high in every HALT cycle, low otherwise.

Reset
REQ-033 reset=1 SHALL force, on the next edge: state IDLE, pc=START_ADDR, retired=0, instr_valid=0, halted=0, overriding all other inputs.
REQ-034 reset asserted mid-RUN or mid-stall SHALL abandon the current instruction without retiring it.
REQ-035 While reset=1, imem_addr SHALL equal START_ADDR.

Verification
REQ-036 Start, then 5 sequential cycles, ROM[i]=i -> pc 0,1,2,3,4; instr 9'h000..9'h004; retired=5 after.
REQ-037 At pc=5, jmp_en=1, jmp_addr=10'h200 -> next cycle pc=10'h200, instr=ROM[200h], instr_valid never drops.
REQ-038 At pc=10'h003, br_en=1, br_off=8'hFC (-4) -> pc=10'h3FF; next sequential cycle pc=10'h000 (wrap).
REQ-039 At pc=7, stall=1 for 3 cycles with jmp_en=1 -> pc=7 and instr unchanged for 3 cycles, retired unchanged; then pc=8.
REQ-040 At pc=9, done_i=1 with jmp_en=1 -> HALT, halted=1, pc=9, instr_valid=0, retired+1; start=1 -> RUN at pc=0, retired=0.
REQ-041 reset=1 during a stall at pc=12 -> next cycle IDLE, pc=0, retired=0, instr_valid=0; start ignored until reset=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequences the PC through IDLE/RUN/HALT, steers a
// synchronous instruction memory so each redirect lands with no bubble.
module instr_fetch #(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            done_i,
    input  logic            stall,
    input  logic            jmp_en,
    input  logic [PC_W-1:0] jmp_addr,
    input  logic            br_en,
    input  logic [7:0]      br_off,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_rdata,
    output logic [8:0]      instr,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic [15:0]     retired
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [15:0]     retired_reg, retired_next;
    logic            halted_reg;
    logic            retire;
    logic [PC_W+7:0] br_off_ext;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] seq_target;
    logic            run;

    assign br_off_ext = {{PC_W{br_off[7]}}, br_off};
    assign br_target  = pc_reg + br_off_ext[PC_W-1:0];
    assign seq_target = pc_reg + PC_W'(1);
    assign run        = (state_reg == RUN);

    // The memory address is chosen from the same priority as the PC update so
    // the data arriving next cycle always matches the next pc.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        retired_next = retired_reg;
        imem_addr    = START_ADDR;
        retire       = 1'b0;
        if (reset) begin
            state_next   = IDLE;
            pc_next      = START_ADDR;
            retired_next = '0;
        end else begin
            case (state_reg)
                IDLE, HALT: begin
                    if (start) begin
                        state_next   = RUN;
                        pc_next      = START_ADDR;
                        retired_next = '0;
                    end
                end
                RUN: begin
                    if (done_i) begin
                        state_next = HALT;
                        retire     = 1'b1;
                    end else if (stall) begin
                        imem_addr = pc_reg;
                    end else if (jmp_en) begin
                        imem_addr = jmp_addr;
                        pc_next   = jmp_addr;
                        retire    = 1'b1;
                    end else if (br_en) begin
                        imem_addr = br_target;
                        pc_next   = br_target;
                        retire    = 1'b1;
                    end else begin
                        imem_addr = seq_target;
                        pc_next   = seq_target;
                        retire    = 1'b1;
                    end
                    if (retire && (retired_reg != 16'hFFFF)) begin
                        retired_next = retired_reg + 16'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    pc_next    = START_ADDR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            pc_reg      <= START_ADDR;
            retired_reg <= '0;
            halted_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            retired_reg <= retired_next;
            halted_reg  <= (state_next == HALT);
        end
    end

    // Instruction bus is forced to zero whenever nothing live is presented.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_instr_gate
            assign instr[gi] = imem_rdata[gi] & run;
        end
    endgenerate

    assign instr_valid = run;
    assign pc          = pc_reg;
    assign halted      = halted_reg;
    assign retired     = retired_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected per-cycle outputs go into a
// scoreboard queue when inputs are driven and are popped after the edge.
module tb_instr_fetch;

    localparam int PC_W = 10;

    logic            clk = 1'b0;
    logic            reset, start, done_i, stall, jmp_en, br_en;
    logic [PC_W-1:0] jmp_addr;
    logic [7:0]      br_off;
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      imem_rdata;
    logic [8:0]      instr;
    logic            instr_valid;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic [15:0]     retired;

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;

    typedef struct {
        logic            v;
        logic [PC_W-1:0] pc;
        logic [8:0]      instr;
        logic            h;
        logic [15:0]     ret;
    } exp_t;

    exp_t sb[$];
    logic [8:0] rom [0:(1<<PC_W)-1];

    always #5 clk = ~clk;

    // ROM[i]=i for the low half; bit 9 of the address flips bit 8 of the data
    // so that 10'h200 and 10'h3FF read back distinguishable words.
    initial begin
        for (int i = 0; i < (1 << PC_W); i++) begin
            logic [9:0] a;
            a = 10'(i);
            rom[i] = a[8:0] ^ {a[9], 8'h00};
        end
    end

    always @(posedge clk) imem_rdata <= rom[imem_addr];

    instr_fetch #(.PC_W(PC_W), .START_ADDR('0)) dut (
        .clk(clk), .reset(reset), .start(start), .done_i(done_i),
        .stall(stall), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
        .br_en(br_en), .br_off(br_off), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .halted(halted), .retired(retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push the outputs expected after the coming edge, clock, then pop/compare.
    task automatic cyc(input logic v, input logic [PC_W-1:0] p, input logic [8:0] ins,
                       input logic h, input logic [15:0] r);
        exp_t e;
        e.v = v; e.pc = p; e.instr = ins; e.h = h; e.ret = r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cycle_no++;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("instr_valid", 32'(instr_valid), 32'(e.v));
            chk("pc", 32'(pc), 32'(e.pc));
            chk("instr", 32'(instr), 32'(e.instr));
            chk("halted", 32'(halted), 32'(e.h));
            chk("retired", 32'(retired), 32'(e.ret));
        end
        $display("cyc %0d: v=%b pc=%h instr=%h halted=%b retired=%0d",
                 cycle_no, instr_valid, pc, instr, halted, retired);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; done_i = 1'b0; stall = 1'b0;
        jmp_en = 1'b0; br_en = 1'b0; jmp_addr = '0; br_off = '0;
        @(posedge clk); #1;
        chk("imem_addr_in_reset", 32'(imem_addr), 32'h0);
        cyc(1'b0, 10'h000, 9'h000, 1'b0, 16'd0);

        reset = 1'b0;
        cyc(1'b0, 10'h000, 9'h000, 1'b0, 16'd0);
        chk("imem_addr_idle", 32'(imem_addr), 32'h0);

        // Start; hold start high one extra cycle to show it is ignored in RUN.
        start = 1'b1;
        cyc(1'b1, 10'h000, 9'h000, 1'b0, 16'd0);
        cyc(1'b1, 10'h001, 9'h001, 1'b0, 16'd1);
        start = 1'b0;
        for (int k = 2; k <= 5; k++) cyc(1'b1, 10'(k), 9'(k), 1'b0, 16'(k));

        // Jump at pc=5 to 10'h200.
        jmp_en = 1'b1; jmp_addr = 10'h200;
        #1 chk("imem_addr_jmp", 32'(imem_addr), 32'h200);
        cyc(1'b1, 10'h200, 9'h100, 1'b0, 16'd6);
        jmp_addr = 10'h003;
        cyc(1'b1, 10'h003, 9'h003, 1'b0, 16'd7);

        // Backward branch at pc=3 by -4 wraps to 10'h3FF, then to 0.
        jmp_en = 1'b0; br_en = 1'b1; br_off = 8'hFC;
        #1 chk("imem_addr_br", 32'(imem_addr), 32'h3FF);
        cyc(1'b1, 10'h3FF, 9'h0FF, 1'b0, 16'd8);
        br_en = 1'b0;
        #1 chk("imem_addr_wrap", 32'(imem_addr), 32'h000);
        cyc(1'b1, 10'h000, 9'h000, 1'b0, 16'd9);
        jmp_en = 1'b1; jmp_addr = 10'h007;
        cyc(1'b1, 10'h007, 9'h007, 1'b0, 16'd10);

        // Stall at pc=7 for 3 cycles; the concurrent jump must lose.
        stall = 1'b1; jmp_addr = 10'h055;
        #1 chk("imem_addr_stall", 32'(imem_addr), 32'h007);
        for (int k = 0; k < 3; k++) cyc(1'b1, 10'h007, 9'h007, 1'b0, 16'd10);
        stall = 1'b0; jmp_en = 1'b0;
        cyc(1'b1, 10'h008, 9'h008, 1'b0, 16'd11);
        cyc(1'b1, 10'h009, 9'h009, 1'b0, 16'd12);

        // Halt at pc=9 with a competing jump; done retires the instruction.
        done_i = 1'b1; jmp_en = 1'b1; jmp_addr = 10'h100;
        #1 chk("imem_addr_done", 32'(imem_addr), 32'h000);
        cyc(1'b0, 10'h009, 9'h000, 1'b1, 16'd13);
        stall = 1'b1; br_en = 1'b1;
        cyc(1'b0, 10'h009, 9'h000, 1'b1, 16'd13);
        chk("imem_addr_halt", 32'(imem_addr), 32'h000);
        done_i = 1'b0; stall = 1'b0; jmp_en = 1'b0; br_en = 1'b0;

        start = 1'b1;
        cyc(1'b1, 10'h000, 9'h000, 1'b0, 16'd0);
        start = 1'b0;
        for (int k = 1; k <= 12; k++) cyc(1'b1, 10'(k), 9'(k), 1'b0, 16'(k));

        // Reset during a stall at pc=12, with start also high.
        stall = 1'b1;
        cyc(1'b1, 10'h00C, 9'h00C, 1'b0, 16'd12);
        reset = 1'b1; start = 1'b1;
        #1 chk("imem_addr_reset_run", 32'(imem_addr), 32'h000);
        cyc(1'b0, 10'h000, 9'h000, 1'b0, 16'd0);
        cyc(1'b0, 10'h000, 9'h000, 1'b0, 16'd0);
        reset = 1'b0; start = 1'b0; stall = 1'b0;
        cyc(1'b0, 10'h000, 9'h000, 1'b0, 16'd0);
        start = 1'b1;
        cyc(1'b1, 10'h000, 9'h000, 1'b0, 16'd0);
        start = 1'b0;
        cyc(1'b1, 10'h001, 9'h001, 1'b0, 16'd1);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
